div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle integer divider serving the execute stage. It accepts DIV/DIVU operands and a start request from EX, and performs a 32-step restoring division, one quotient bit per cycle. It returns a 64-bit {remainder, quotient} result with a ready flag, and EX holds the pipeline stalled until that flag rises. EX writes result_o[63:32] to HI and result_o[31:0] to LO.

## Interface
Parameters:
- none; widths come from `RegBus (32) and `DoubleRegBus (64).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  `DivStart (1) requests or holds an operation; `DivStop (0) releases it.
- annul_i  in  1  pipeline flush; aborts an in-flight division.
- result_o  out  64  {remainder[31:0], quotient[31:0]}.
- ready_o  out  1  `DivResultReady (1) when result_o is valid.

## Operation
- State register holds one of four states: DivFree, DivByZero, DivOn, DivEnd.
- DivFree
  - If start_i=1, annul_i=0 and opdata2_i=0: go to DivByZero.
  - If start_i=1, annul_i=0 and opdata2_i≠0: go to DivOn.
    - Set cnt=0.
    - Capture the divisor: |opdata2_i| if signed and opdata2_i[31]=1, else the raw value.
    - Initialise the 65-bit working register to {32'b0, dividend, 1'b0}, where the dividend is |opdata1_i| if signed and negative, else the raw value.
  - Otherwise stay in DivFree. ready_o=0 and result_o=0.
- DivByZero: on the next edge, go to DivEnd with result_o=0 and ready_o=1.
- DivOn, annul_i=1: go to DivFree with ready_o=0 and result_o=0.
- DivOn, annul_i=0 and cnt<32: perform one restoring step.
  - diff = {1'b0, work[63:32]} − {1'b0, divisor}.
  - If diff[32]=1, the step restores: work <= work<<1.
  - Otherwise: work <= {diff[31:0], work[31:0], 1'b1}.
  - cnt <= cnt+1.
- DivOn, cnt=32: go to DivEnd and set ready_o=1.
  - quotient = work[31:0]; remainder = work[64:33].
  - If signed and opdata1_i[31]^opdata2_i[31] (signs captured at start): negate the quotient (two's complement).
  - If signed and the dividend was negative: negate the remainder.
  - result_o = {remainder, quotient}.
- DivEnd
  - If start_i=0: go to DivFree with ready_o=0 and result_o=0.
  - If start_i=1: hold state, result_o and ready_o.
- Operands are sampled only on the DivFree→DivOn/DivByZero edge; later input changes are ignored.
- All arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
- annul_i is ignored in DivFree (no start accepted while it is high), in DivByZero and in DivEnd.

## Timing
- Reset (rst=0 at an edge): state=DivFree, cnt=0, work=0, result_o=0, ready_o=0. Reset overrides every state, including mid-division.
- Latency, normal division: start_i is sampled at edge E0.
  - E0: enter DivOn.
  - E1..E32: the 32 division steps.
  - E33: enter DivEnd; ready_o is high after E33.
  - EX therefore stalls for 34 cycles.
- Latency, divide by zero: ready_o is high after E1 (2-cycle stall).
- Release: start_i low in DivEnd drops ready_o after the next edge.
- Back-to-back operations: at least one DivFree cycle separates two divisions.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
Constants in defines.v:
- `DivFree 2'b00, `DivByZero 2'b01, `DivOn 2'b10, `DivEnd 2'b11.
- `DivResultReady, `DivResultNotReady.
- `DivStart, `DivStop.
- `RegBus, `DoubleRegBus, `ZeroWord.

The block is a single module with no sub-module. The subtract-compare step is inline combinational logic.

## Test plan
- Unsigned 100 / 7: result_o = {32'd2, 32'd14}; ready_o rises exactly 34 cycles after start is sampled.
- Signed −7 / 2 (0xFFFFFFF9, 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero, 5 / 0 (signed and unsigned): result_o = 0; ready_o high 2 cycles after start.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Abort cases:
  - annul_i pulsed at step 10: the block returns to DivFree with ready_o=0; a following 50 / 5 takes the full 34 cycles and returns {0, 10}.
  - rst=0 at step 20: all outputs are 0 after that edge.
- Hold and release: start_i held high 5 cycles into DivEnd keeps result_o and ready_o stable; dropping start_i clears both after one edge. Changing operands during DivOn does not alter the result.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared widths, state encoding and helpers for div_unit
package div_unit_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [REG_BUS-1:0] abs_if_signed(input logic is_signed,
                                                       input logic [REG_BUS-1:0] v);
    return (is_signed && v[REG_BUS-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-step restoring divider returning {remainder, quotient}
module div_unit
  import div_unit_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);

  div_state_e         state, state_next;
  logic [5:0]         cnt;
  logic [64:0]        work;
  logic [REG_BUS-1:0] divisor;
  logic               neg_quot, neg_rem;
  logic [32:0]        diff;
  logic [REG_BUS-1:0] quot_fix, rem_fix;
  logic               accept;

  assign accept   = (start_i == DIV_START) && !annul_i;
  assign diff     = {1'b0, work[63:32]} - {1'b0, divisor};
  assign quot_fix = neg_quot ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem_fix  = neg_rem  ? (~work[64:33] + 32'd1) : work[64:33];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= DIV_FREE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_FREE: begin
        if (accept) begin
          state_next = (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: state_next = DIV_END;
      DIV_ON: begin
        if (annul_i) begin
          state_next = DIV_FREE;
        end else if (cnt == DIV_STEPS) begin
          state_next = DIV_END;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_next = DIV_FREE;
        end
      end
      default: state_next = DIV_FREE;
    endcase
  end

  // Operand magnitudes and result signs are latched once; inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= ZERO_WORD;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= {ZERO_WORD, ZERO_WORD};
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= {ZERO_WORD, ZERO_WORD};
          ready_o  <= DIV_RESULT_NOT_READY;
          if (accept && (opdata2_i != ZERO_WORD)) begin
            cnt      <= 6'd0;
            divisor  <= abs_if_signed(signed_div_i, opdata2_i);
            work     <= {32'd0, abs_if_signed(signed_div_i, opdata1_i), 1'b0};
            neg_quot <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem  <= signed_div_i && opdata1_i[31];
          end
        end
        DIV_BY_ZERO: begin
          result_o <= {ZERO_WORD, ZERO_WORD};
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            result_o <= {ZERO_WORD, ZERO_WORD};
            ready_o  <= DIV_RESULT_NOT_READY;
          end else if (cnt < DIV_STEPS) begin
            // Borrow out means the divisor did not fit: shift in a 0 and keep the old partial remainder.
            if (diff[32]) begin
              work <= {work[63:0], 1'b0};
            end else begin
              work <= {diff[31:0], work[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            result_o <= {ZERO_WORD, ZERO_WORD};
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: begin
          result_o <= {ZERO_WORD, ZERO_WORD};
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int passed;
  int total;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div = sgn;
    op1        = a;
    op2        = b;
    start      = 1'b1;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      cycles = cycles + 1;
      @(negedge clk);
    end while (!ready && cycles < 100);
  endtask

  task automatic release_op(input string tag);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rel_ready"}, 64'(ready), 64'd0);
    check({tag, "_rel_result"}, result, 64'd0);
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int c;
    start_op(sgn, a, b);
    wait_ready(c);
    check({tag, "_latency"}, 64'(c), 64'(lat));
    check({tag, "_result"}, result, exp);
    release_op(tag);
  endtask

  task automatic watch_no_ready(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int c;
    passed     = 0;
    total      = 0;
    rst        = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    start      = 1'b0;
    annul      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
    run_div("s5_0", 1'b1, 32'd5, 32'd0, 64'd0, 2);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34);
    run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);

    // annul in the middle of a division
    start_op(1'b0, 32'd123, 32'd4);
    @(posedge clk);
    @(negedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    annul = 1'b0;
    start = 1'b0;
    watch_no_ready("annul_no_late_ready", 40);
    run_div("after_annul_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34);

    // reset in the middle of a division
    start_op(1'b0, 32'd1000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_result", result, 64'd0);
    rst   = 1'b1;
    start = 1'b0;
    watch_no_ready("midrst_no_late_ready", 40);

    // operands change during the division, then hold start in the end state
    start_op(1'b0, 32'd1000, 32'd7);
    @(posedge clk);
    @(negedge clk);
    start_op(1'b1, 32'd5, 32'd0);
    wait_ready(c);
    check("hold_latency", 64'(c), 64'd33);
    check("hold_result", result, {32'd6, 32'd142});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold_ready_%0d", i), 64'(ready), 64'd1);
      check($sformatf("hold_result_%0d", i), result, {32'd6, 32'd142});
    end
    release_op("hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
